// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and single-cycle result helper for alu_mc
package alu_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIVU = 4'd12;
    localparam logic [3:0] ALU_REMU = 4'd13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Operands arrive pre-extended to 64 bits (zero- and sign-extended copies) so one
    // function serves every WIDTH; the caller keeps the low WIDTH bits. Multi-cycle and
    // illegal opcodes fall to the default and yield 0.
    function automatic logic [63:0] alu_single(input logic [3:0] op, input logic [63:0] au,
                                               input logic [63:0] bu, input logic [63:0] as,
                                               input logic [63:0] bs, input logic [5:0] sh);
        logic [63:0] r;
        r = '0;
        case (op)
            ALU_ADD:  r = au + bu;
            ALU_SUB:  r = au - bu;
            ALU_AND:  r = au & bu;
            ALU_OR:   r = au | bu;
            ALU_SLL:  r = au << sh;
            ALU_SRL:  r = au >> sh;
            ALU_XOR:  r = au ^ bu;
            ALU_SRA:  r = $signed(as) >>> sh;
            ALU_SLT:  r = 64'($signed(as) < $signed(bs));
            ALU_SLTU: r = 64'(au < bu);
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiplier / restoring divider, one bit per cycle
//   clk, rst          clock, synchronous active-high reset
//   start_i           load operands and begin WIDTH iterations
//   div_i, rem_i      divide (else multiply); return remainder (else quotient)
//   op_a_i, op_b_i    multiplicand/dividend, multiplier/divisor
//   busy_o            iterations in progress
//   done_o            final iteration this cycle; result_o valid
//   result_o          result as it will stand after the final iteration
import alu_pkg::*;

module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             rem_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);
    logic             busy_q, div_q, rem_q;
    logic [CW-1:0]    cnt_q;
    // acc: product accumulator or partial remainder
    // sh:  multiplier (shifts right) or dividend/quotient (shifts left)
    // md:  multiplicand (shifts left) or divisor
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, md_q, md_d;
    logic [WIDTH:0]   r_shift, diff;

    always_comb begin
        r_shift = {acc_q, sh_q[WIDTH-1]};
        diff    = r_shift - {1'b0, md_q};
        // diff[WIDTH] set means the trial subtraction went negative: restore.
        // A zero divisor never goes negative, giving all-ones quotient and remainder = dividend.
        acc_d   = div_q ? (diff[WIDTH] ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0])
                        : acc_q + (sh_q[0] ? md_q : '0);
        sh_d    = div_q ? {sh_q[WIDTH-2:0], ~diff[WIDTH]} : sh_q >> 1;
        md_d    = div_q ? md_q : md_q << 1;
    end

    assign busy_o   = busy_q;
    assign done_o   = busy_q && cnt_q == '0;
    assign result_o = (div_q && !rem_q) ? sh_d : acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            rem_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            md_q   <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= div_i;
            rem_q  <= rem_i;
            cnt_q  <= CW'(WIDTH - 1);
            acc_q  <= '0;
            sh_q   <= div_i ? op_a_i : op_b_i;
            md_q   <= div_i ? op_b_i : op_a_i;
        end else if (busy_q) begin
            busy_q <= cnt_q != '0;
            cnt_q  <= cnt_q - 1'b1;
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            md_q   <= md_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with valid/ready handshakes and registered result/flags
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       operation handshake (ready only in IDLE)
//   opcode, operand_1/2       operation select and operands (operand_2 low bits = shift amount)
//   out_valid / out_ready     result handshake; result held until accepted
//   alu_result, zero, illegal registered result, result==0 flag, unsupported-opcode flag
import alu_pkg::*;

module alu_mc #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, single, md_res;
    logic             zero_q, zero_d, ill_q, ill_d;
    logic             accept, is_md, is_ill, md_done, md_busy;

    assign in_ready   = state_q == ST_IDLE && !md_busy;
    assign out_valid  = state_q == ST_DONE;
    assign alu_result = res_q;
    assign zero       = zero_q;
    assign illegal    = ill_q;
    assign accept     = in_valid && in_ready;
    assign is_md      = MULDIV_EN && opcode >= ALU_MUL && opcode <= ALU_REMU;
    assign is_ill     = opcode > ALU_REMU || (!MULDIV_EN && opcode >= ALU_MUL);
    // Illegal and mul/div opcodes already evaluate to 0 here.
    assign single     = WIDTH'(alu_single(opcode, 64'(operand_1), 64'(operand_2),
                                          64'($signed(operand_1)), 64'($signed(operand_2)),
                                          6'(operand_2[SW-1:0])));

    if (MULDIV_EN) begin : g_md
        alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
            .clk      (clk),
            .rst      (rst),
            .start_i  (accept && is_md),
            .div_i    (opcode != ALU_MUL),
            .rem_i    (opcode == ALU_REMU),
            .op_a_i   (operand_1),
            .op_b_i   (operand_2),
            .busy_o   (md_busy),
            .done_o   (md_done),
            .result_o (md_res)
        );
    end else begin : g_no_md
        assign md_busy = 1'b0;
        assign md_done = 1'b0;
        assign md_res  = '0;
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ill_d   = ill_q;
        if (accept) begin
            state_d = !is_md ? ST_DONE : (opcode == ALU_MUL ? ST_MUL : ST_DIV);
            res_d   = is_md ? res_q : single;
            ill_d   = is_md ? ill_q : is_ill;
        end else if ((state_q == ST_MUL || state_q == ST_DIV) && md_done) begin
            state_d = ST_DONE;
            res_d   = md_res;
            ill_d   = 1'b0;
        end else if (state_q == ST_DONE && out_ready) begin
            state_d = ST_IDLE;
        end
        zero_d = res_d == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: random and directed checks of alu_mc (32-bit, 32-bit without mul/div, 8-bit) against a reference model
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [3:0]  opcode;
    logic [31:0] operand_1, operand_2;
    logic        ir_a, ov_a, z_a, il_a;
    logic        ir_n, ov_n, z_n, il_n;
    logic        ir_8, ov_8, z_8, il_8;
    logic [31:0] res_a, res_n;
    logic [7:0]  res_8;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .MULDIV_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .opcode(opcode),
        .operand_1(operand_1), .operand_2(operand_2), .out_valid(ov_a), .out_ready(out_ready),
        .alu_result(res_a), .zero(z_a), .illegal(il_a));

    alu_mc #(.WIDTH(32), .MULDIV_EN(1'b0)) u_nmd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_n), .opcode(opcode),
        .operand_1(operand_1), .operand_2(operand_2), .out_valid(ov_n), .out_ready(out_ready),
        .alu_result(res_n), .zero(z_n), .illegal(il_n));

    alu_mc #(.WIDTH(8), .MULDIV_EN(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_8), .opcode(opcode),
        .operand_1(operand_1[7:0]), .operand_2(operand_2[7:0]), .out_valid(ov_8), .out_ready(out_ready),
        .alu_result(res_8), .zero(z_8), .illegal(il_8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input int op, input logic [63:0] a_in, input logic [63:0] b_in,
                                            input int w, input bit md, output bit ill);
        logic [63:0] m, a, b, r;
        longint      sa, sb;
        int          sh;
        m   = (64'd1 << w) - 64'd1;
        a   = a_in & m;
        b   = b_in & m;
        sh  = int'(b % 64'(w));
        sa  = longint'(a << (64 - w)) >>> (64 - w);
        sb  = longint'(b << (64 - w)) >>> (64 - w);
        ill = op >= 14 || (!md && op >= 11);
        case (op)
            1:  r = a + b;
            2:  r = a - b;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a << sh;
            6:  r = a >> sh;
            7:  r = a ^ b;
            8:  r = 64'(sa >>> sh);
            9:  r = 64'(sa < sb);
            10: r = 64'(a < b);
            11: r = a * b;
            12: r = (b == 0) ? m : a / b;
            13: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        if (ill) r = '0;
        return r & m;
    endfunction

    task automatic verify(input string tag, input int lat, input int lat_e, input logic [63:0] r,
                          input logic [63:0] r_e, input logic z, input logic il, input logic il_e);
        check({tag, "_lat"}, 64'(lat), 64'(lat_e));
        check({tag, "_res"}, r, r_e);
        check({tag, "_zero"}, 64'(z), 64'(r_e == 0));
        check({tag, "_ill"}, 64'(il), 64'(il_e));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] r_out);
        int          lat [3];
        int          le  [3];
        logic [63:0] r   [3];
        logic [63:0] e   [3];
        logic        z   [3];
        logic        il  [3];
        bit          ie  [3];
        @(negedge clk);
        check("in_ready", 64'(ir_a), 64'd1);
        in_valid  = 1'b1;
        opcode    = op;
        operand_1 = a;
        operand_2 = b;
        out_ready = hold == 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        opcode    = 4'($urandom);
        operand_1 = $urandom;
        operand_2 = $urandom;
        lat = '{0, 0, 0};
        r   = '{0, 0, 0};
        z   = '{0, 0, 0};
        il  = '{0, 0, 0};
        for (int c = 1; c <= 40 && lat[0] == 0; c++) begin
            @(negedge clk);
            if (lat[1] == 0 && ov_n) begin lat[1] = c; r[1] = 64'(res_n); z[1] = z_n; il[1] = il_n; end
            if (lat[2] == 0 && ov_8) begin lat[2] = c; r[2] = 64'(res_8); z[2] = z_8; il[2] = il_8; end
            if (ov_a) begin lat[0] = c; r[0] = 64'(res_a); z[0] = z_a; il[0] = il_a; end
            else check("busy_ready", 64'(ir_a), 64'd0);
        end
        e[0] = ref_alu(int'(op), 64'(a), 64'(b), 32, 1'b1, ie[0]);
        e[1] = ref_alu(int'(op), 64'(a), 64'(b), 32, 1'b0, ie[1]);
        e[2] = ref_alu(int'(op), 64'(a), 64'(b), 8, 1'b1, ie[2]);
        le[0] = (ie[0] || op < 11) ? 1 : 33;
        le[1] = (ie[1] || op < 11) ? 1 : 33;
        le[2] = (ie[2] || op < 11) ? 1 : 9;
        verify("w32", lat[0], le[0], r[0], e[0], z[0], il[0], ie[0]);
        verify("nomd", lat[1], le[1], r[1], e[1], z[1], il[1], ie[1]);
        verify("w8", lat[2], le[2], r[2], e[2], z[2], il[2], ie[2]);
        r_out = r[0][31:0];
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            opcode    = 4'($urandom);
            operand_1 = $urandom;
            operand_2 = $urandom;
            @(negedge clk);
            check("hold_valid", 64'(ov_a), 64'd1);
            check("hold_res", 64'(res_a), e[0]);
            check("hold_ready", 64'(ir_a), 64'd0);
            check("hold_res_w8", 64'(res_8), e[2]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 64'(ov_a), 64'd0);
        check("release_ready", 64'(ir_a), 64'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          spurious;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        operand_1 = '0;
        operand_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ir_a), 64'd1);
        check("rst_valid", 64'(ov_a), 64'd0);
        check("rst_res", 64'(res_a), 64'd0);
        check("rst_zero", 64'(z_a), 64'd1);
        check("rst_ill", 64'(il_a), 64'd0);
        rst = 1'b0;

        run_op(4'd1, 32'hFFFF_FFFF, 32'd1, 0, r);      check("add_wrap", 64'(r), 64'h0);
        run_op(4'd8, 32'h8000_0000, 32'h24, 0, r);     check("sra", 64'(r), 64'hF800_0000);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, r);      check("slt", 64'(r), 64'd1);
        run_op(4'd10, 32'hFFFF_FFFF, 32'd1, 0, r);     check("sltu", 64'(r), 64'd0);
        run_op(4'd12, 32'd100, 32'd7, 0, r);           check("divu", 64'(r), 64'd14);
        run_op(4'd13, 32'd100, 32'd7, 0, r);           check("remu", 64'(r), 64'd2);
        run_op(4'd12, 32'hDEAD_BEEF, 32'd0, 0, r);     check("divu0", 64'(r), 64'hFFFF_FFFF);
        run_op(4'd13, 32'h1234, 32'd0, 0, r);          check("remu0", 64'(r), 64'h1234);
        run_op(4'd15, 32'h55, 32'h66, 0, r);           check("op15", 64'(r), 64'h0);
        run_op(4'd1, 32'h0000_00FF, 32'd2, 0, r);
        run_op(4'd11, 32'h0F, 32'h11, 0, r);
        run_op(4'd2, 32'd5, 32'd9, 5, r);
        run_op(4'd11, 32'h0001_0003, 32'd5, 0, r);     check("mul", 64'(r), 64'h0005_000F);

        @(negedge clk);
        in_valid  = 1'b1;
        opcode    = 4'd11;
        operand_1 = 32'h1234_5678;
        operand_2 = 32'h9ABC_DEF1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(ov_a), 64'd0);
        check("abort_ready", 64'(ir_a), 64'd1);
        check("abort_res", 64'(res_a), 64'd0);
        check("abort_zero", 64'(z_a), 64'd1);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov_a) spurious++;
        end
        check("abort_no_result", 64'(spurious), 64'd0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
            run_op(op, a, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
